router_batch_sequencer: RTL and testbench

//  Parametrised next-generation router sequencer. Scans a rectangular output

---
 rtl/router_batch_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_router_batch_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_batch_sequencer.sv
// Row router batch sequencer: scans an OW x OH output map with stride S and hands
// coordinates to ROW_COUNT routers per batch, then sequences compare and pop phases.
module router_batch_sequencer #(
  parameter int ROW_COUNT  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int ROW_ID_W   = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1,
  parameter int BATCH_W    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_o_width,
  input  logic [ADDR_WIDTH-1:0] i_o_height,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  input  logic                  i_addr_empty,
  input  logic                  i_data_empty,
  output logic [ROW_ID_W-1:0]   o_row_id,
  output logic [ADDR_WIDTH-1:0] o_o_x,
  output logic [ADDR_WIDTH-1:0] o_o_y,
  output logic [ROW_COUNT-1:0]  o_row_mask,
  output logic                  o_ag_en,
  output logic                  o_ac_en,
  output logic                  o_tile_read_en,
  output logic                  o_pop_en,
  output logic                  o_reg_clear,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [BATCH_W-1:0]    o_batch_cnt
);

  // state | meaning
  // IDLE  | waiting for i_start
  // GEN   | one coordinate per cycle into the current batch
  // STALL | single bubble before compare
  // CMP   | address compare / tile read until address FIFOs drain
  // POP   | data pop until data FIFOs drain
  // CLR   | one-cycle router clear, batch count update
  // FIN   | job end; o_done pulses as the FSM returns to IDLE
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_STALL = 3'd2,
    S_CMP   = 3'd3,
    S_POP   = 3'd4,
    S_CLR   = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  typedef struct packed {
    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ow;
    logic [ADDR_WIDTH-1:0]   oh;
    logic [ADDR_WIDTH-1:0]   s;
    logic [ADDR_WIDTH-1:0]   x_idx;
    logic [ADDR_WIDTH-1:0]   y_idx;
    logic [ADDR_WIDTH-1:0]   x_pos;
    logic [ADDR_WIDTH-1:0]   y_pos;
    logic [ROW_ID_W-1:0]     row;
    logic [ROW_COUNT-1:0]    mask;
    logic                    ag_en;
    logic                    done;
    logic                    first;
    logic                    last;
    logic [BATCH_W-1:0]      batch;
  } regs_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ROW_ID_W-1:0]   ROW_ONE   = ROW_ID_W'(1);
  localparam logic [ROW_ID_W-1:0]   LAST_ROW  = ROW_ID_W'(ROW_COUNT - 1);
  localparam logic [ROW_COUNT-1:0]  MASK_ONE  = ROW_COUNT'(1);
  localparam logic [BATCH_W-1:0]    BATCH_ONE = BATCH_W'(1);

  regs_t r_q, r_d;
  logic  last_pt;
  logic  cmp_en;
  logic  pop_en;

  // Termination compares indices, not index*S products, so product wrap is harmless.
  assign last_pt = (r_q.x_idx == (r_q.ow - ADDR_ONE)) && (r_q.y_idx == (r_q.oh - ADDR_ONE));

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) r_q <= '0;
    else         r_q <= r_d;
  end

  always_comb begin
    r_d        = r_q;
    r_d.done   = 1'b0;
    cmp_en     = 1'b0;
    pop_en     = 1'b0;

    case (r_q.state)
      S_IDLE: begin
        if (i_start) begin
          r_d.ow    = i_o_width;
          r_d.oh    = i_o_height;
          r_d.s     = (i_stride == '0) ? ADDR_ONE : i_stride;
          r_d.batch = '0;
          r_d.x_idx = '0;
          r_d.y_idx = '0;
          r_d.x_pos = '0;
          r_d.y_pos = '0;
          r_d.row   = '0;
          r_d.last  = 1'b0;
          if ((i_o_width == '0) || (i_o_height == '0)) begin
            r_d.state = S_FIN;
          end else begin
            r_d.state = S_GEN;
            r_d.ag_en = 1'b1;
            r_d.mask  = MASK_ONE;
          end
        end
      end

      S_GEN: begin
        if (last_pt) begin
          r_d.ag_en = 1'b0;
          r_d.last  = 1'b1;
          r_d.state = S_STALL;
        end else begin
          if (r_q.y_idx == (r_q.oh - ADDR_ONE)) begin
            r_d.y_idx = '0;
            r_d.y_pos = '0;
            r_d.x_idx = r_q.x_idx + ADDR_ONE;
            r_d.x_pos = r_q.x_pos + r_q.s;
          end else begin
            r_d.y_idx = r_q.y_idx + ADDR_ONE;
            r_d.y_pos = r_q.y_pos + r_q.s;
          end
          if (r_q.row == LAST_ROW) begin
            r_d.ag_en = 1'b0;
            r_d.row   = '0;
            r_d.state = S_STALL;
          end else begin
            r_d.row  = r_q.row + ROW_ONE;
            r_d.mask = r_q.mask | (MASK_ONE << r_d.row);
          end
        end
      end

      S_STALL: begin
        r_d.first = 1'b1;
        r_d.state = S_CMP;
      end

      S_CMP: begin
        cmp_en    = r_q.first || !i_addr_empty;
        r_d.first = 1'b0;
        if (!r_q.first && i_addr_empty) begin
          r_d.first = 1'b1;
          r_d.state = S_POP;
        end
      end

      S_POP: begin
        pop_en    = r_q.first || !i_data_empty;
        r_d.first = 1'b0;
        if (!r_q.first && i_data_empty) r_d.state = S_CLR;
      end

      S_CLR: begin
        r_d.mask = '0;
        if (r_q.batch != '1) r_d.batch = r_q.batch + BATCH_ONE;
        if (r_q.last) begin
          r_d.last  = 1'b0;
          r_d.state = S_FIN;
        end else begin
          r_d.ag_en = 1'b1;
          r_d.mask  = MASK_ONE;
          r_d.state = S_GEN;
        end
      end

      S_FIN: begin
        r_d.done  = 1'b1;
        r_d.x_idx = '0;
        r_d.y_idx = '0;
        r_d.x_pos = '0;
        r_d.y_pos = '0;
        r_d.row   = '0;
        r_d.mask  = '0;
        r_d.state = S_IDLE;
      end

      default: r_d.state = S_IDLE;
    endcase

    // Abort wins over every other input and clears config as well as state.
    if (i_abort) r_d = '0;
  end

  assign o_row_id       = r_q.row;
  assign o_o_x          = r_q.x_pos;
  assign o_o_y          = r_q.y_pos;
  assign o_row_mask     = r_q.mask;
  assign o_ag_en        = r_q.ag_en;
  assign o_ac_en        = cmp_en;
  assign o_tile_read_en = cmp_en;
  assign o_pop_en       = pop_en;
  assign o_reg_clear    = (r_q.state == S_CLR);
  assign o_busy         = (r_q.state != S_IDLE);
  assign o_done         = r_q.done;
  assign o_batch_cnt    = r_q.batch;

endmodule

// File: tb/tb_router_batch_sequencer.sv
// Scoreboard bench for router_batch_sequencer: a job-level model fills expectation
// queues, a monitor pops them whenever the DUT presents coordinates, clears or done.
module tb_router_batch_sequencer;
  localparam int R  = 4;
  localparam int AW = 8;
  localparam int RW = 2;
  localparam int BW = 16;

  logic          i_clk = 1'b0;
  logic          i_nrst = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [AW-1:0] i_o_width = '0;
  logic [AW-1:0] i_o_height = '0;
  logic [AW-1:0] i_stride = '0;
  logic          i_addr_empty = 1'b1;
  logic          i_data_empty = 1'b1;
  logic [RW-1:0] o_row_id;
  logic [AW-1:0] o_o_x, o_o_y;
  logic [R-1:0]  o_row_mask;
  logic          o_ag_en, o_ac_en, o_tile_read_en, o_pop_en, o_reg_clear, o_busy, o_done;
  logic [BW-1:0] o_batch_cnt;

  always #5 i_clk = ~i_clk;

  router_batch_sequencer #(.ROW_COUNT(R), .ADDR_WIDTH(AW), .ROW_ID_W(RW), .BATCH_W(BW)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start), .i_abort(i_abort),
    .i_o_width(i_o_width), .i_o_height(i_o_height), .i_stride(i_stride),
    .i_addr_empty(i_addr_empty), .i_data_empty(i_data_empty),
    .o_row_id(o_row_id), .o_o_x(o_o_x), .o_o_y(o_o_y), .o_row_mask(o_row_mask),
    .o_ag_en(o_ag_en), .o_ac_en(o_ac_en), .o_tile_read_en(o_tile_read_en),
    .o_pop_en(o_pop_en), .o_reg_clear(o_reg_clear), .o_busy(o_busy), .o_done(o_done),
    .o_batch_cnt(o_batch_cnt)
  );

  typedef struct packed {
    logic [RW-1:0] row;
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic [R-1:0]  mask;
  } coord_t;

  coord_t        coord_q[$];
  logic [R-1:0]  bmask_q[$];
  logic [BW-1:0] done_q[$];
  int            cmp_q[$];
  int            pop_q[$];
  int            vectors = 0;
  int            errors = 0;
  int            ac_run = 0, tile_run = 0, pop_run = 0;
  int            force_cmp = -1, force_pop = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    vectors++;
    errors++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  function automatic logic [63:0] all_outs();
    return {o_row_id, o_o_x, o_o_y, o_row_mask, o_ag_en, o_ac_en, o_tile_read_en,
            o_pop_en, o_reg_clear, o_busy, o_done, o_batch_cnt};
  endfunction

  task automatic flush();
    coord_q.delete(); bmask_q.delete(); done_q.delete(); cmp_q.delete(); pop_q.delete();
    ac_run = 0; tile_run = 0; pop_run = 0;
  endtask

  // Reference: raster order x outer, y inner; ROW_COUNT points per batch.
  task automatic model_job(input int ow, input int oh, input int s);
    int se, n, total, nb, rem;
    coord_t c;
    se = (s == 0) ? 1 : s;
    total = ow * oh;
    n = 0;
    for (int x = 0; x < ow; x++)
      for (int y = 0; y < oh; y++) begin
        c.row  = RW'(n % R);
        c.x    = AW'(x * se);
        c.y    = AW'(y * se);
        c.mask = R'((1 << ((n % R) + 1)) - 1);
        coord_q.push_back(c);
        n++;
      end
    nb = (total + R - 1) / R;
    for (int b = 0; b < nb; b++) begin
      rem = total - b * R;
      bmask_q.push_back(R'((1 << ((rem >= R) ? R : rem)) - 1));
    end
    done_q.push_back(BW'(nb));
  endtask

  // Monitor
  initial forever begin
    coord_t c;
    int e;
    @(negedge i_clk);
    if (o_ag_en) begin
      if (coord_q.size() == 0) unexpected("coord", {o_row_id, o_o_x, o_o_y, o_row_mask});
      else begin
        c = coord_q.pop_front();
        check("coord", {o_row_id, o_o_x, o_o_y, o_row_mask}, c);
      end
    end
    if (o_reg_clear) begin
      if (bmask_q.size() == 0) unexpected("reg_clear", o_row_mask);
      else check("batch_mask", o_row_mask, bmask_q.pop_front());
    end
    if (o_done) begin
      if (done_q.size() == 0) unexpected("done", o_batch_cnt);
      else begin
        check("batch_cnt", o_batch_cnt, done_q.pop_front());
        check("busy_at_done", o_busy, 0);
      end
    end
    if (o_ac_en || o_tile_read_en) begin
      ac_run += int'(o_ac_en);
      tile_run += int'(o_tile_read_en);
    end else if (ac_run != 0 || tile_run != 0) begin
      e = (cmp_q.size() != 0) ? cmp_q.pop_front() : 0;
      check("ac_en_cycles", ac_run, e);
      check("tile_rd_cycles", tile_run, e);
      ac_run = 0; tile_run = 0;
    end
    if (o_pop_en) pop_run++;
    else if (pop_run != 0) begin
      e = (pop_q.size() != 0) ? pop_q.pop_front() : 0;
      check("pop_en_cycles", pop_run, e);
      pop_run = 0;
    end
  end

  // Address FIFO responder: stays non-empty for n cycles after the first CMP cycle.
  initial begin
    int rem;
    bit trk;
    trk = 0;
    rem = 0;
    forever begin
      @(negedge i_clk);
      if (!trk && o_ac_en) begin
        rem = (force_cmp >= 0) ? force_cmp : int'($urandom_range(0, 5));
        cmp_q.push_back(rem + 1);
        trk = 1;
        #1 i_addr_empty = (rem == 0);
      end else if (trk && o_ac_en) begin
        rem--;
        #1 i_addr_empty = (rem <= 0);
      end else if (trk) begin
        trk = 0;
        #1 i_addr_empty = 1'($urandom_range(0, 1));
      end
    end
  end

  // Data FIFO responder
  initial begin
    int rem;
    bit trk;
    trk = 0;
    rem = 0;
    forever begin
      @(negedge i_clk);
      if (!trk && o_pop_en) begin
        rem = (force_pop >= 0) ? force_pop : int'($urandom_range(0, 3));
        pop_q.push_back(rem + 1);
        trk = 1;
        #1 i_data_empty = (rem == 0);
      end else if (trk && o_pop_en) begin
        rem--;
        #1 i_data_empty = (rem <= 0);
      end else if (trk) begin
        trk = 0;
        #1 i_data_empty = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic start_job(input int ow, input int oh, input int s);
    model_job(ow, oh, s);
    @(posedge i_clk); #1;
    i_o_width = AW'(ow); i_o_height = AW'(oh); i_stride = AW'(s);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("busy_after_start", o_busy, 1);
  endtask

  task automatic run_job(input int ow, input int oh, input int s, input bit disturb);
    int cyc;
    bit seen;
    start_job(ow, oh, s);
    cyc = 1;
    seen = 0;
    while (!seen && cyc < 3000) begin
      if (disturb) begin
        i_start = o_busy && ($urandom_range(0, 5) == 0);
        i_o_width = AW'($urandom); i_o_height = AW'($urandom); i_stride = AW'($urandom);
      end
      @(negedge i_clk);
      if (o_done) seen = 1;
      else begin
        @(posedge i_clk); #1;
        cyc++;
      end
    end
    i_start = 1'b0;
    if (!seen) begin
      unexpected("job_timeout", cyc);
      i_nrst = 1'b0; #1 flush(); #1 i_nrst = 1'b1;
    end else begin
      check("idle_outputs_at_done", {o_row_id, o_o_x, o_o_y, o_row_mask, o_ag_en, o_busy}, 0);
      if (ow == 0 || oh == 0) check("zero_size_latency", cyc, 2);
      @(negedge i_clk);
      check("done_one_cycle", o_done, 0);
      check("queues_drained", coord_q.size() + bmask_q.size() + done_q.size()
            + cmp_q.size() + pop_q.size(), 0);
    end
  endtask

  initial begin
    int n;
    i_nrst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 check("reset_outputs", all_outs(), 0);
    i_nrst = 1'b1;

    run_job(2, 2, 1, 0);
    run_job(3, 2, 2, 0);
    force_cmp = 5; force_pop = 3;
    run_job(2, 2, 1, 0);
    force_cmp = -1; force_pop = -1;
    run_job(0, 3, 1, 0);
    run_job(3, 0, 5, 0);
    run_job(1, 1, 0, 0);
    run_job(40, 3, 7, 1);
    run_job(5, 7, 255, 1);

    // Abort in the first POP cycle of a job
    start_job(3, 3, 1);
    n = 0;
    do begin @(negedge i_clk); n++; end while (!o_pop_en && n < 300);
    check("pop_seen_before_abort", o_pop_en, 1);
    #1 i_abort = 1'b1;
    @(posedge i_clk); #1;
    i_abort = 1'b0;
    flush();
    @(negedge i_clk);
    check("abort_outputs", all_outs(), 0);
    repeat (5) @(negedge i_clk);
    check("abort_no_done_idle", {o_busy, o_done}, 0);

    // Async reset in the middle of GEN
    start_job(5, 5, 3);
    n = 0;
    do begin @(negedge i_clk); n++; end while (!o_ag_en && n < 50);
    #1 i_nrst = 1'b0;
    #1 check("reset_mid_gen_outputs", all_outs(), 0);
    flush();
    @(posedge i_clk); #1 i_nrst = 1'b1;
    run_job(2, 2, 1, 0);

    for (int j = 0; j < 25; j++)
      run_job($urandom_range(0, 9), $urandom_range(0, 9),
              ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
